// File: rtl/crc_param_gen.sv
// rtl/crc_param_gen.sv - parameterised bit-serial CRC generator with valid/ready handshake
module crc_param_gen #(
  parameter int               DATA_W  = 5,
  parameter int               CRC_W   = 32,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(32'h04C11DB7),
  parameter logic [CRC_W-1:0] INIT    = '1,
  parameter logic [CRC_W-1:0] XOR_OUT = '1,
  parameter bit               REFLECT = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic [DATA_W-1:0]       data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CRC_W-1:0]        crc_out,
  output logic [DATA_W+CRC_W-1:0] data_out,
  output logic                    busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [DATA_W-1:0]  word;
  logic [CNT_W-1:0]   cnt;
  logic [CRC_W-1:0]   crc;
  logic [CRC_W-1:0]   crc_step;
  logic [CRC_W-1:0]   crc_final;
  logic [CNT_W-1:0]   bit_idx;
  logic [DATA_W-1:0]  word_sh;
  logic               cur_bit;
  logic               fb;
  logic               accept;
  logic               last_step;

  function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    r = '0;
    for (int i = 0; i < CRC_W; i++) begin
      r[i] = v[CRC_W-1-i];
    end
    return r;
  endfunction

  // One CRC bit-step and the reported result; the word register is left intact
  // so data_out can report it, and the bit is picked by the down-counter instead.
  always_comb begin
    bit_idx   = REFLECT ? (CNT_W'(DATA_W) - cnt) : (cnt - CNT_W'(1));
    word_sh   = word >> bit_idx;
    cur_bit   = word_sh[0];
    fb        = crc[CRC_W-1] ^ cur_bit;
    crc_step  = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    crc_final = (REFLECT ? bitrev(crc_step) : crc_step) ^ XOR_OUT;
    last_step = (cnt == CNT_W'(1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    accept = in_valid && in_ready;
  end

  // Datapath: capture on accept, shift one bit per clock, latch result entering DONE.
  // The raw crc register is never post-processed so chained words continue from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      word     <= '0;
      cnt      <= '0;
      crc      <= INIT;
      crc_out  <= '0;
      data_out <= '0;
    end else begin
      if (state == IDLE && accept) begin
        word <= data_in;
        cnt  <= CNT_W'(DATA_W);
        if (in_first) crc <= INIT;
      end
      if (state == SHIFT && cnt != '0) begin
        crc <= crc_step;
        cnt <= cnt - CNT_W'(1);
        if (last_step) begin
          crc_out  <= crc_final;
          data_out <= {word, crc_final};
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_param_gen.sv
// tb/tb_crc_param_gen.sv - scoreboard bench for crc_param_gen across several configurations
module tb_crc_param_gen;

  localparam int N = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] in_valid;
  logic         in_first;
  logic [7:0]   data_in;
  logic         out_ready;
  logic [N-1:0] ir, ov, bsy;
  logic [31:0]  crc_o [N];
  logic [63:0]  dout [N];

  logic [7:0]  c0;
  logic [15:0] d0;
  logic [31:0] c1, c2, c3, c4;
  logic [39:0] d1, d2, d4;
  logic [36:0] d3;

  assign crc_o[0] = {24'h0, c0};
  assign crc_o[1] = c1;
  assign crc_o[2] = c2;
  assign crc_o[3] = c3;
  assign crc_o[4] = c4;
  assign dout[0]  = {48'h0, d0};
  assign dout[1]  = {24'h0, d1};
  assign dout[2]  = {24'h0, d2};
  assign dout[3]  = {27'h0, d3};
  assign dout[4]  = {24'h0, d4};

  crc_param_gen #(.DATA_W(8), .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .REFLECT(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir[0]), .in_first(in_first),
    .data_in(data_in), .out_valid(ov[0]), .out_ready(out_ready), .crc_out(c0), .data_out(d0), .busy(bsy[0]));

  crc_param_gen #(.DATA_W(8), .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'h0), .XOR_OUT(32'h0), .REFLECT(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir[1]), .in_first(in_first),
    .data_in(data_in), .out_valid(ov[1]), .out_ready(out_ready), .crc_out(c1), .data_out(d1), .busy(bsy[1]));

  crc_param_gen #(.DATA_W(8), .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'h0), .XOR_OUT(32'hFFFFFFFF), .REFLECT(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(ir[2]), .in_first(in_first),
    .data_in(data_in), .out_valid(ov[2]), .out_ready(out_ready), .crc_out(c2), .data_out(d2), .busy(bsy[2]));

  crc_param_gen u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(ir[3]), .in_first(in_first),
    .data_in(data_in[4:0]), .out_valid(ov[3]), .out_ready(out_ready), .crc_out(c3), .data_out(d3), .busy(bsy[3]));

  crc_param_gen #(.DATA_W(8), .REFLECT(1'b1)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[4]), .in_ready(ir[4]), .in_first(in_first),
    .data_in(data_in), .out_valid(ov[4]), .out_ready(out_ready), .crc_out(c4), .data_out(d4), .busy(bsy[4]));

  int          dw [N];
  int          cw [N];
  logic [31:0] poly [N];
  logic [31:0] init [N];
  logic [31:0] xo [N];
  bit          rf [N];
  logic [31:0] run [N];
  logic [31:0] last [N];

  typedef struct {
    int          idx;
    logic [31:0] crc;
    logic [63:0] dout;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] cmask(input int w);
    return (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [31:0] mstep(input logic [31:0] c_in, input logic [63:0] d, input int w,
                                        input int c_w, input logic [31:0] p, input bit refl);
    logic [31:0] c;
    logic        b, f;
    c = c_in;
    for (int i = 0; i < w; i++) begin
      b = refl ? d[i] : d[w-1-i];
      f = c[c_w-1] ^ b;
      c = ((c << 1) ^ (f ? p : 32'h0)) & cmask(c_w);
    end
    return c;
  endfunction

  function automatic logic [31:0] mfin(input logic [31:0] c, input int c_w, input bit refl, input logic [31:0] x);
    logic [31:0] r;
    r = c;
    if (refl) begin
      r = '0;
      for (int i = 0; i < c_w; i++) r[i] = c[c_w-1-i];
    end
    return r ^ x;
  endfunction

  task automatic send(input int idx, input logic [7:0] d, input bit first);
    exp_t        e;
    logic [63:0] dm;
    int          k;
    k = 0;
    @(negedge clk);
    while (!ir[idx] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_before_send", 64'(ir[idx]), 64'(1));
    in_valid[idx] = 1'b1;
    data_in       = d;
    in_first      = first;
    @(posedge clk);
    #1;
    in_valid[idx] = 1'b0;
    if (first) run[idx] = init[idx];
    run[idx] = mstep(run[idx], 64'(d), dw[idx], cw[idx], poly[idx], rf[idx]);
    dm     = 64'(d) & ((64'h1 << dw[idx]) - 64'h1);
    e.idx  = idx;
    e.crc  = mfin(run[idx], cw[idx], rf[idx], xo[idx]);
    e.dout = (dm << cw[idx]) | 64'(e.crc);
    sb.push_back(e);
  endtask

  task automatic collect(input int idx, input int start_cyc);
    exp_t e;
    int   cyc;
    cyc = start_cyc;
    while (!ov[idx] && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("out_valid_latency", 64'(cyc), 64'(dw[idx]));
    e = sb.pop_front();
    chk("crc_out", 64'(crc_o[idx]), 64'(e.crc));
    chk("data_out", dout[idx], e.dout);
    last[idx] = e.crc;
  endtask

  initial begin
    logic [31:0] hold_crc;
    logic [63:0] hold_dout;
    exp_t        drop;
    bit          seen;

    dw   = '{8, 8, 8, 5, 8};
    cw   = '{8, 32, 32, 32, 32};
    poly = '{32'h07, 32'h04C11DB7, 32'h04C11DB7, 32'h04C11DB7, 32'h04C11DB7};
    init = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    xo   = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    rf   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst       = 1'b1;
    in_valid  = '0;
    in_first  = 1'b0;
    data_in   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      run[i]  = init[i];
      last[i] = 32'h0;
      chk("reset_out_valid", 64'(ov[i]), 64'(0));
      chk("reset_in_ready", 64'(ir[i]), 64'(1));
      chk("reset_busy", 64'(bsy[i]), 64'(0));
      chk("reset_crc_out", 64'(crc_o[i]), 64'(0));
      chk("reset_data_out", dout[i], 64'(0));
    end

    // CRC-8 single words and chaining
    send(0, 8'h01, 1'b1);
    chk("busy_in_shift", 64'(bsy[0]), 64'(1));
    chk("in_ready_low_in_shift", 64'(ir[0]), 64'(0));
    collect(0, 0);
    chk("crc8_01_const", 64'(crc_o[0]), 64'h07);
    send(0, 8'h80, 1'b1);
    collect(0, 0);
    chk("crc8_80_const", 64'(crc_o[0]), 64'h89);
    send(0, 8'h00, 1'b0);
    collect(0, 0);
    chk("crc8_chain_8000", 64'(crc_o[0]), 64'(mstep(32'h0, 64'h8000, 16, 8, 32'h07, 1'b0)));

    // CRC-32 constants
    send(1, 8'h01, 1'b1);
    collect(1, 0);
    chk("crc32_01_const", 64'(crc_o[1]), 64'h04C11DB7);
    chk("crc32_01_dout_const", dout[1], {24'h0, 8'h01, 32'h04C11DB7});
    send(2, 8'h00, 1'b1);
    collect(2, 0);
    chk("crc32_xorout_const", 64'(crc_o[2]), 64'hFFFFFFFF);

    // Back-pressure, ignored offers in SHIFT and DONE, result stability
    out_ready = 1'b0;
    send(0, 8'h3C, 1'b1);
    chk("crc_hold_in_shift", 64'(crc_o[0]), 64'(last[0]));
    @(negedge clk);
    in_valid[0] = 1'b1;
    data_in     = 8'hFF;
    in_first    = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    collect(0, 1);
    hold_crc  = crc_o[0];
    hold_dout = dout[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid[0] = (i == 1);
      data_in     = 8'hA5;
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      chk("stall_out_valid", 64'(ov[0]), 64'(1));
      chk("stall_crc_stable", 64'(crc_o[0]), 64'(hold_crc));
      chk("stall_dout_stable", dout[0], hold_dout);
      chk("stall_in_ready_low", 64'(ir[0]), 64'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 64'(ir[0]), 64'(1));
    chk("release_out_valid", 64'(ov[0]), 64'(0));
    send(0, 8'h5A, 1'b0);
    collect(0, 0);

    // Reset mid-SHIFT discards the word
    send(1, 8'hA7, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_out_valid", 64'(ov[1]), 64'(0));
    chk("midrst_crc_out", 64'(crc_o[1]), 64'(0));
    chk("midrst_busy", 64'(bsy[1]), 64'(0));
    chk("midrst_in_ready", 64'(ir[1]), 64'(1));
    drop = sb.pop_back();
    for (int i = 0; i < N; i++) begin
      run[i]  = init[i];
      last[i] = 32'h0;
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 seen = seen | ov[1];
    end
    chk("midrst_no_result", 64'(seen), 64'(0));
    send(1, 8'hA7, 1'b1);
    collect(1, 0);
    chk("midrst_rerun_vs_model", 64'(crc_o[1]), 64'(mstep(32'h0, 64'hA7, 8, 32, 32'h04C11DB7, 1'b0)));

    // Default parameters, 5-bit words
    send(3, 8'b000_11001, 1'b1);
    collect(3, 0);
    send(3, 8'b000_00110, 1'b0);
    collect(3, 0);

    // Reflected configuration
    send(4, 8'h01, 1'b1);
    collect(4, 0);
    send(4, 8'hC3, 1'b0);
    collect(4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
